// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default field widths, the ID->EX payload
// layout and the skid-controller state encoding.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int IMM_W   = 16;
  localparam int ALUOP_W = 3;
  localparam int WSEL_W  = 5;

  // The write enable sits in the LSB so a stage can clear it without decoding fields.
  typedef struct packed {
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [IMM_W-1:0]   imm;
    logic               datasrc;
    logic [ALUOP_W-1:0] aluop;
    logic [WSEL_W-1:0]  wsel;
    logic               we;
  } id_ex_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_t;

  function automatic int bundle_width(input int dw, input int iw, input int aw, input int ww);
    return 2 * dw + iw + aw + ww + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Payload-agnostic 2-entry skid controller: FSM, registered ready and load
// enables for the main (output) and skid (overflow) registers.
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_main_in,
  output logic load_main_skid,
  output logic load_skid,
  output logic clear_main
);

  skid_state_t state, next_state;
  logic accept, rel;

  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign rel       = out_valid & out_ready;

  // ready is precomputed from the next state so out_ready never reaches in_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != ST_SKID);
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: next_state = accept ? ST_FULL : ST_EMPTY;
        ST_FULL: begin
          if (accept && !rel)      next_state = ST_SKID;
          else if (!accept && rel) next_state = ST_EMPTY;
          else                     next_state = ST_FULL;
        end
        ST_SKID:  next_state = rel ? ST_FULL : ST_SKID;
        default:  next_state = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = (next_state == ST_EMPTY);
    if (flush) begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: load_main_in = accept;
        ST_FULL: begin
          load_main_in = accept & rel;
          load_skid    = accept & ~rel;
        end
        ST_SKID:  load_main_skid = rel;
        default: begin
          load_main_in   = 1'b0;
          load_main_skid = 1'b0;
          load_skid      = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID->EX stage register with valid/ready handshake and 2-entry skid buffer;
// main and skid hold the packed decode bundle.
module id_ex_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int IMM_W   = pipe_pkg::IMM_W,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W,
  parameter int WSEL_W  = pipe_pkg::WSEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_rd1,
  input  logic [DATA_W-1:0]  in_rd2,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_datasrc,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [WSEL_W-1:0]  in_wsel,
  input  logic               in_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_rd1,
  output logic [DATA_W-1:0]  out_rd2,
  output logic [IMM_W-1:0]   out_imm,
  output logic               out_datasrc,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [WSEL_W-1:0]  out_wsel,
  output logic               out_we
);

  localparam int PW = bundle_width(DATA_W, IMM_W, ALUOP_W, WSEL_W);

  logic [PW-1:0] in_pay, main_q, skid_q;
  logic load_main_in, load_main_skid, load_skid, clear_main;

  assign in_pay = {in_rd1, in_rd2, in_imm, in_datasrc, in_aluop, in_wsel, in_we};
  assign {out_rd1, out_rd2, out_imm, out_datasrc, out_aluop, out_wsel, out_we} = main_q;

  pipe_skid_ctrl u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main_in   (load_main_in),
    .load_main_skid (load_main_skid),
    .load_skid      (load_skid),
    .clear_main     (clear_main)
  );

  // main register; the write-enable bit (LSB) is forced low whenever the stage goes empty
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_pay;
      else if (load_main_skid) main_q <= skid_q;
      if (clear_main)          main_q[0] <= 1'b0;
    end
  end

  // overflow register, filled only when main is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_pay;
    end
  end

endmodule
